// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Purpose  : Shares one byte-wide serial transmit port between NUM_REQ
//            requesters. Each requester owns a one-byte holding slot; a
//            round-robin scheduler drains full slots onto serial_out with a
//            one-cycle serial_wren_out strobe, honouring serial_ready_in.
// Options  : `define SERIAL_ARB_LINE_LOCK_EN to keep text lines (terminated
//            by 8'h0A) from different requesters from interleaving.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]   req_wren_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  input  logic                 serial_ready_in,
  output logic [7:0]           serial_out,
  output logic                 serial_wren_out,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic [CNT_W-1:0]     sent_count_out
);

  localparam int                 PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0]   PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [7:0]         LINE_END = 8'h0A;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  // Scheduler condition, re-derived every cycle from slot flags and sink ready
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2
  } sched_state_e;

  logic [7:0]         slot_q [NUM_REQ];
  logic [7:0]         slot_d [NUM_REQ];
  logic [NUM_REQ-1:0] full_q,  full_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [7:0]         out_q,   out_d;
  logic               wren_q,  wren_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] accept;
  logic               found;
  logic [PTR_W-1:0]   sel;
  sched_state_e       state;

`ifdef SERIAL_ARB_LINE_LOCK_EN
  logic               locked_q, locked_d;
  logic [PTR_W-1:0]   owner_q,  owner_d;

  // While a line is open only its owner may transmit, even if its slot is empty
  always_comb begin
    eligible = locked_q ? (full_q & (ONE_HOT0 << owner_q)) : full_q;
  end
`else
  // Every full slot competes for the port
  always_comb begin
    eligible = full_q;
  end
`endif

  // Rotating search: first eligible slot after the last one served
  always_comb begin : p_select
    logic [PTR_W-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Classify the current cycle for the scheduler
  always_comb begin
    if (full_q == '0) begin
      state = S_IDLE;
    end else if (serial_ready_in) begin
      state = S_ISSUE;
    end else begin
      state = S_STALL;
    end
  end

  // Next-state logic: slot fills plus at most one issue per cycle
  always_comb begin
    accept  = req_wren_in & ~full_q;
    slot_d  = slot_q;
    full_d  = full_q | accept;
    ptr_d   = ptr_q;
    out_d   = out_q;
    wren_d  = 1'b0;
    grant_d = '0;
    cnt_d   = cnt_q;
`ifdef SERIAL_ARB_LINE_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_d[i] = req_data_in[8*i +: 8];
      end
    end
    case (state)
      S_ISSUE: begin
        // An accept never targets the issued slot: accepts need an empty slot
        if (found) begin
          out_d       = slot_q[sel];
          wren_d      = 1'b1;
          grant_d     = ONE_HOT0 << sel;
          full_d[sel] = 1'b0;
          ptr_d       = sel;
          cnt_d       = cnt_q + CNT_ONE;
`ifdef SERIAL_ARB_LINE_LOCK_EN
          locked_d    = (slot_q[sel] != LINE_END);
          owner_d     = sel;
`endif
        end
      end
      default: begin
        // IDLE and STALL: slots and pointer hold, no strobe
      end
    endcase
  end

  // State registers with synchronous reset; slot data needs no reset
  always_ff @(posedge clock) begin
    slot_q <= slot_d;
    if (reset) begin
      full_q   <= '0;
      ptr_q    <= PTR_RST;
      out_q    <= 8'h00;
      wren_q   <= 1'b0;
      grant_q  <= '0;
      cnt_q    <= '0;
`ifdef SERIAL_ARB_LINE_LOCK_EN
      locked_q <= 1'b0;
      owner_q  <= '0;
`endif
    end else begin
      full_q   <= full_d;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      wren_q   <= wren_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ARB_LINE_LOCK_EN
      locked_q <= locked_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign req_ready_out   = ~full_q;
  assign serial_out      = out_q;
  assign serial_wren_out = wren_q;
  assign grant_out       = grant_q;
  assign sent_count_out  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_arbiter
// Purpose  : Self-checking bench for serial_tx_arbiter (2 requesters, 4-bit
//            sent counter) using a queue/array reference model plus directed
//            ordering checks and a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arbiter;

  localparam int N  = 2;
  localparam int CW = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*8-1:0] req_data_in;
  logic [N-1:0]   req_wren_in;
  logic [N-1:0]   req_ready_out;
  logic           serial_ready_in;
  logic [7:0]     serial_out;
  logic           serial_wren_out;
  logic [N-1:0]   grant_out;
  logic [CW-1:0]  sent_count_out;

  serial_tx_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_data_in     (req_data_in),
    .req_wren_in     (req_wren_in),
    .req_ready_out   (req_ready_out),
    .serial_ready_in (serial_ready_in),
    .serial_out      (serial_out),
    .serial_wren_out (serial_wren_out),
    .grant_out       (grant_out),
    .sent_count_out  (sent_count_out)
  );

  always #10 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot contents, last requester served, byte count, lock
  bit           m_full [N];
  bit [7:0]     m_data [N];
  int           m_last;
  int           m_count;
  bit [7:0]     m_out;
  bit           m_wren;
  int           m_gidx;
  bit           m_locked;
  int           m_owner;

  bit [7:0]     issued [$];
  bit [7:0]     exp_order [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_len"}, issued.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < issued.size(); i++) begin
      chk(tag, issued[i], exp_order[i]);
    end
  endtask

  // One clock edge: advance the model from the applied inputs, then compare
  task automatic step();
    bit          old_full [N];
    int          sel;
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ready;
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_last = N - 1; m_count = 0; m_out = 8'h00; m_wren = 1'b0;
      m_locked = 1'b0; m_owner = 0;
    end else begin
      old_full = m_full;
      sel = -1;
      if (serial_ready_in) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
`ifdef SERIAL_ARB_LINE_LOCK_EN
          if (sel < 0 && m_full[idx] && (!m_locked || idx == m_owner)) sel = idx;
`else
          if (sel < 0 && m_full[idx]) sel = idx;
`endif
        end
      end
      if (sel >= 0) begin
        m_out = m_data[sel];
        m_wren = 1'b1;
        m_gidx = sel;
        m_full[sel] = 1'b0;
        m_last = sel;
        m_count = (m_count + 1) % (1 << CW);
        m_locked = (m_out != 8'h0A);
        m_owner = sel;
      end else begin
        m_wren = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_wren_in[i] && !old_full[i]) begin
          m_full[i] = 1'b1;
          m_data[i] = req_data_in[8*i +: 8];
        end
      end
    end
    #1;
    exp_grant = m_wren ? N'(1 << m_gidx) : '0;
    for (int i = 0; i < N; i++) exp_ready[i] = ~m_full[i];
    chk("wren",  serial_wren_out, m_wren);
    chk("grant", grant_out,       exp_grant);
    chk("data",  serial_out,      m_out);
    chk("count", sent_count_out,  m_count);
    chk("ready", req_ready_out,   exp_ready);
    if (serial_wren_out === 1'b1) issued.push_back(serial_out);
  endtask

  task automatic write1(input int r, input bit [7:0] d);
    req_wren_in = '0;
    req_wren_in[r] = 1'b1;
    req_data_in[8*r +: 8] = d;
    step();
    req_wren_in = '0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req_wren_in = '0;
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
    issued.delete();
  endtask

  initial begin
    reset = 1'b1;
    req_data_in = '0;
    req_wren_in = '0;
    serial_ready_in = 1'b1;

    // Reset held 200 ns; model checks ready=11, wren=0, count=0 each edge
    do_reset(10);

    // Single byte from req0
    write1(0, 8'h48);
    step();
    chk("first_byte", serial_out, 8'h48);
    chk("first_grant", grant_out, 2'b01);
    step();
    chk("first_wren_one_cycle", serial_wren_out, 1'b0);

    // Simultaneous writes, twice: order 41,42,41,42
    do_reset(1);
    exp_order = '{8'h41, 8'h42, 8'h41, 8'h42};
    for (int rep = 0; rep < 2; rep++) begin
      req_data_in = {8'h42, 8'h41};
      req_wren_in = 2'b11;
      step();
      req_wren_in = '0;
      for (int i = 0; i < 3; i++) step();
    end
    chk_order("rr_order");

    // Backpressure: first byte held, second write dropped
    issued.delete();
    serial_ready_in = 1'b0;
    write1(0, 8'h11);
    step();
    write1(0, 8'h22);
    step();
    step();
    chk("stall_ready0", req_ready_out[0], 1'b0);
    serial_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    exp_order = '{8'h11};
    chk_order("stall_order");

    // Counter wrap: 17 bytes into a 4-bit counter
    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      write1(i % 2, 8'(i));
      step();
    end
    step();
    chk("cnt_wrap", sent_count_out, 1);

    // Line lock: req0 sends "AB\n" with gaps while req1 holds 8'h5A
    do_reset(1);
    write1(0, 8'h41);
    write1(1, 8'h5A);
    step(); step();
    write1(0, 8'h42);
    step(); step();
    write1(0, 8'h0A);
    for (int i = 0; i < 5; i++) step();
`ifdef SERIAL_ARB_LINE_LOCK_EN
    exp_order = '{8'h41, 8'h42, 8'h0A, 8'h5A};
`else
    exp_order = '{8'h41, 8'h5A, 8'h42, 8'h0A};
`endif
    chk_order("line_order");

    // Randomized traffic with occasional mid-operation reset
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      serial_ready_in = ($urandom_range(0, 9) < 7);
      for (int r = 0; r < N; r++) begin
        req_wren_in[r] = $urandom_range(0, 1);
        req_data_in[8*r +: 8] = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      end
      step();
    end
    reset = 1'b0;
    req_wren_in = '0;
    serial_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
